// File: rtl/pipe_buf_ctrl_pkg.sv
// Shared types for the RV32I inter-stage pipeline buffers and their controller.
package pipe_buf_ctrl_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        FREEZE     = 2'd3
    } pipe_state_e;

    typedef struct packed {
        logic [31:0] PC;
        logic [31:0] Curr_Instr;
        logic [31:0] PC_plus4;
    } if_id_reg;

    typedef struct packed {
        logic [31:0] PC;
        logic [31:0] Curr_Instr;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  ALUOp;
        logic        ALUSrc;
        logic        Branch;
        logic        Jump;
        logic        MemRead;
        logic        MemWrite;
        logic        RegWrite;
        logic        MemtoReg;
    } id_ex_reg;

    typedef struct packed {
        logic [31:0] PC;
        logic [31:0] Curr_Instr;
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic        MemRead;
        logic        MemWrite;
        logic        RegWrite;
        logic        MemtoReg;
    } ex_mem_reg;

    typedef struct packed {
        logic [31:0] PC;
        logic [31:0] Curr_Instr;
        logic [31:0] alu_result;
        logic [31:0] mem_rdata;
        logic [4:0]  rd;
        logic        RegWrite;
        logic        MemtoReg;
    } mem_wb_reg;

    // Bubbles: all control bits clear so nothing is ever written.
    localparam if_id_reg  IF_ID_BUBBLE  = '{Curr_Instr: NOP_INSTR, default: '0};
    localparam id_ex_reg  ID_EX_BUBBLE  = '{Curr_Instr: NOP_INSTR, default: '0};
    localparam ex_mem_reg EX_MEM_BUBBLE = '{Curr_Instr: NOP_INSTR, default: '0};
    localparam mem_wb_reg MEM_WB_BUBBLE = '{Curr_Instr: NOP_INSTR, default: '0};

endpackage

// File: rtl/pipe_hazard_unit.sv
// Combinational hazard resolution: picks the per-cycle pipeline action and
// turns it into buffer load/bubble enables and the PC write enable.
module pipe_hazard_unit
    import pipe_buf_ctrl_pkg::*;
(
    input  logic        reset_n_i,
    input  logic [4:0]  a_rs1_i,
    input  logic [4:0]  a_rs2_i,
    input  logic        b_mem_read_i,
    input  logic [4:0]  b_rd_i,
    input  logic        ex_redirect_i,
    input  logic        dmem_busy_i,
    output pipe_state_e action_o,
    output logic        a_load_o,
    output logic        a_bubble_o,
    output logic        b_load_o,
    output logic        b_bubble_o,
    output logic        cd_load_o,
    output logic        pc_write_o
);

    logic load_use;

    assign load_use = b_mem_read_i && (b_rd_i != 5'd0) &&
                      ((b_rd_i == a_rs1_i) || (b_rd_i == a_rs2_i));

    // Priority select FREEZE > FLUSH > LOAD_STALL > RUN, then derive enables.
    always_comb begin
        action_o = RUN;
        if (dmem_busy_i) begin
            action_o = FREEZE;
        end else if (ex_redirect_i) begin
            action_o = FLUSH;
        end else if (load_use) begin
            action_o = LOAD_STALL;
        end

        a_load_o   = (action_o == RUN);
        a_bubble_o = (action_o == FLUSH);
        b_load_o   = (action_o == RUN);
        b_bubble_o = (action_o == FLUSH) || (action_o == LOAD_STALL);
        cd_load_o  = (action_o != FREEZE);
        pc_write_o = reset_n_i && ((action_o == RUN) || (action_o == FLUSH));
    end

endmodule

// File: rtl/pipe_buf_ctrl.sv
// Owns the IF/ID, ID/EX, EX/MEM and MEM/WB buffers, applies stall/flush/freeze
// and keeps hazard performance counters.
module pipe_buf_ctrl
    import pipe_buf_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W     = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             reset,
    input  if_id_reg         if_id_d,
    input  id_ex_reg         id_ex_d,
    input  ex_mem_reg        ex_mem_d,
    input  mem_wb_reg        mem_wb_d,
    input  logic             ex_redirect,
    input  logic             dmem_busy,
    output if_id_reg         if_id_q,
    output id_ex_reg         id_ex_q,
    output ex_mem_reg        ex_mem_q,
    output mem_wb_reg        mem_wb_q,
    output logic             pc_write,
    output pipe_state_e      pipe_state,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    pipe_state_e      action;
    pipe_state_e      pipe_state_q;
    logic             a_load, a_bubble, b_load, b_bubble, cd_load;
    logic [CNT_W-1:0] cyc_cnt_q, stall_cnt_q, flush_cnt_q, freeze_cnt_q;

    if_id_reg  if_id_bub;
    id_ex_reg  id_ex_bub;
    ex_mem_reg ex_mem_bub;
    mem_wb_reg mem_wb_bub;

    pipe_hazard_unit u_hazard (
        .reset_n_i     (reset),
        .a_rs1_i       (if_id_q.Curr_Instr[19:15]),
        .a_rs2_i       (if_id_q.Curr_Instr[24:20]),
        .b_mem_read_i  (id_ex_q.MemRead),
        .b_rd_i        (id_ex_q.rd),
        .ex_redirect_i (ex_redirect),
        .dmem_busy_i   (dmem_busy),
        .action_o      (action),
        .a_load_o      (a_load),
        .a_bubble_o    (a_bubble),
        .b_load_o      (b_load),
        .b_bubble_o    (b_bubble),
        .cd_load_o     (cd_load),
        .pc_write_o    (pc_write)
    );

    // Bubble images carry this instance's NOP encoding.
    always_comb begin
        if_id_bub             = IF_ID_BUBBLE;
        if_id_bub.Curr_Instr  = NOP_INSTR;
        id_ex_bub             = ID_EX_BUBBLE;
        id_ex_bub.Curr_Instr  = NOP_INSTR;
        ex_mem_bub            = EX_MEM_BUBBLE;
        ex_mem_bub.Curr_Instr = NOP_INSTR;
        mem_wb_bub            = MEM_WB_BUBBLE;
        mem_wb_bub.Curr_Instr = NOP_INSTR;
    end

    // Buffer registers: load, hold or bubble as chosen by the hazard unit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if_id_q  <= if_id_bub;
            id_ex_q  <= id_ex_bub;
            ex_mem_q <= ex_mem_bub;
            mem_wb_q <= mem_wb_bub;
        end else begin
            if (a_bubble) begin
                if_id_q <= if_id_bub;
            end else if (a_load) begin
                if_id_q <= if_id_d;
            end
            if (b_bubble) begin
                id_ex_q <= id_ex_bub;
            end else if (b_load) begin
                id_ex_q <= id_ex_d;
            end
            if (cd_load) begin
                ex_mem_q <= ex_mem_d;
                mem_wb_q <= mem_wb_d;
            end
        end
    end

    // Last action taken plus free-running, wrapping performance counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pipe_state_q <= RUN;
            cyc_cnt_q    <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            pipe_state_q <= action;
            cyc_cnt_q    <= cyc_cnt_q + CNT_W'(1);
            if (action == LOAD_STALL) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (action == FLUSH) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
            if (action == FREEZE) begin
                freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
            end
        end
    end

    assign pipe_state = pipe_state_q;
    assign cyc_cnt    = cyc_cnt_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;

endmodule

// File: tb/tb_pipe_buf_ctrl.sv
// Self-checking bench for pipe_buf_ctrl: behavioural model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_pipe_buf_ctrl;
    import pipe_buf_ctrl_pkg::*;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] LW_X5    = 32'h0000_2283;  // lw x5,0(x0)
    localparam logic [31:0] LW_X0    = 32'h0000_2003;  // lw x0,0(x0)
    localparam logic [31:0] ADD_657  = 32'h0072_8333;  // add x6,x5,x7
    localparam logic [31:0] ADD_600  = 32'h0000_0333;  // add x6,x0,x0
    localparam logic [31:0] ADD_A    = 32'h0041_8133;  // add x2,x3,x4

    logic clk = 1'b0;
    logic reset;
    if_id_reg  if_id_d;
    id_ex_reg  id_ex_d;
    ex_mem_reg ex_mem_d;
    mem_wb_reg mem_wb_d;
    logic ex_redirect, dmem_busy;

    if_id_reg    a_q, a4_q;
    id_ex_reg    b_q, b4_q;
    ex_mem_reg   c_q, c4_q;
    mem_wb_reg   d_q, d4_q;
    logic        pcw, pcw4;
    pipe_state_e st, st4;
    logic [31:0] cyc, stl, fls, frz;
    logic [3:0]  cyc4, stl4, fls4, frz4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pipe_buf_ctrl #(.CNT_W(32), .NOP_INSTR(32'h0000_0013)) dut (
        .clk(clk), .reset(reset),
        .if_id_d(if_id_d), .id_ex_d(id_ex_d), .ex_mem_d(ex_mem_d), .mem_wb_d(mem_wb_d),
        .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
        .if_id_q(a_q), .id_ex_q(b_q), .ex_mem_q(c_q), .mem_wb_q(d_q),
        .pc_write(pcw), .pipe_state(st),
        .cyc_cnt(cyc), .stall_cnt(stl), .flush_cnt(fls), .freeze_cnt(frz)
    );

    pipe_buf_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .if_id_d(if_id_d), .id_ex_d(id_ex_d), .ex_mem_d(ex_mem_d), .mem_wb_d(mem_wb_d),
        .ex_redirect(ex_redirect), .dmem_busy(dmem_busy),
        .if_id_q(a4_q), .id_ex_q(b4_q), .ex_mem_q(c4_q), .mem_wb_q(d4_q),
        .pc_write(pcw4), .pipe_state(st4),
        .cyc_cnt(cyc4), .stall_cnt(stl4), .flush_cnt(fls4), .freeze_cnt(frz4)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- stimulus builders ----------------
    function automatic if_id_reg mk_a(input logic [31:0] pc, input logic [31:0] ins);
        if_id_reg r;
        r.PC = pc; r.Curr_Instr = ins; r.PC_plus4 = pc + 32'd4;
        return r;
    endfunction

    function automatic id_ex_reg mk_b(input logic [31:0] ins, input logic [4:0] rd,
                                      input logic mr, input logic [31:0] s);
        id_ex_reg r;
        r = '0;
        r.PC = s; r.Curr_Instr = ins; r.rs1_data = s ^ 32'h1111_0000;
        r.rs2_data = s + 32'd7; r.imm = ~s; r.rs1 = ins[19:15]; r.rs2 = ins[24:20];
        r.rd = rd; r.ALUOp = s[3:0]; r.MemRead = mr; r.RegWrite = 1'b1; r.MemtoReg = mr;
        return r;
    endfunction

    function automatic ex_mem_reg mk_c(input logic [31:0] s);
        ex_mem_reg r;
        r = '0;
        r.PC = s; r.Curr_Instr = s ^ 32'hA5A5_0033; r.alu_result = s * 32'd3;
        r.rs2_data = ~s; r.rd = s[4:0]; r.RegWrite = 1'b1; r.MemWrite = s[0];
        return r;
    endfunction

    function automatic mem_wb_reg mk_d(input logic [31:0] s);
        mem_wb_reg r;
        r = '0;
        r.PC = s; r.Curr_Instr = s ^ 32'h5A5A_0013; r.alu_result = s + 32'd100;
        r.mem_rdata = s << 2; r.rd = s[9:5]; r.RegWrite = 1'b1; r.MemtoReg = s[1];
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    if_id_reg    m_a;
    id_ex_reg    m_b;
    ex_mem_reg   m_c;
    mem_wb_reg   m_d;
    int          m_state;
    logic [31:0] m_cnt [4];   // index = action code; [0] counts all cycles

    function automatic int model_action();
        logic hz;
        hz = m_b.MemRead && (m_b.rd != 5'd0) &&
             (m_b.rd == m_a.Curr_Instr[19:15] || m_b.rd == m_a.Curr_Instr[24:20]);
        if (dmem_busy) return 3;
        if (ex_redirect) return 2;
        if (hz) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        int act;
        if (!reset) begin
            m_a = '0; m_a.Curr_Instr = NOP;
            m_b = '0; m_b.Curr_Instr = NOP;
            m_c = '0; m_c.Curr_Instr = NOP;
            m_d = '0; m_d.Curr_Instr = NOP;
            m_state = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = '0;
        end else begin
            act = model_action();
            if (act == 0) begin
                m_a = if_id_d; m_b = id_ex_d;
            end else if (act == 1) begin
                m_b = '0; m_b.Curr_Instr = NOP;
            end else if (act == 2) begin
                m_a = '0; m_a.Curr_Instr = NOP;
                m_b = '0; m_b.Curr_Instr = NOP;
            end
            if (act != 3) begin
                m_c = ex_mem_d; m_d = mem_wb_d;
            end
            m_state = act;
            m_cnt[0] = m_cnt[0] + 32'd1;
            if (act != 0) m_cnt[act] = m_cnt[act] + 32'd1;
        end
    end

    // Per-cycle comparison of both DUT builds against the model.
    always @(negedge clk) begin : cmp
        int   act;
        logic e_pcw;
        act   = model_action();
        e_pcw = reset && (act == 0 || act == 2);
        check("A",        256'(a_q),  256'(m_a));
        check("B",        256'(b_q),  256'(m_b));
        check("C",        256'(c_q),  256'(m_c));
        check("D",        256'(d_q),  256'(m_d));
        check("pc_write", 256'(pcw),  256'(e_pcw));
        check("state",    256'(st),   256'(m_state));
        check("cyc",      256'(cyc),  256'(m_cnt[0]));
        check("stall",    256'(stl),  256'(m_cnt[1]));
        check("flush",    256'(fls),  256'(m_cnt[2]));
        check("freeze",   256'(frz),  256'(m_cnt[3]));
        check("A4",       256'(a4_q), 256'(m_a));
        check("pcw4",     256'(pcw4), 256'(e_pcw));
        check("cyc4",     256'(cyc4), 256'(m_cnt[0][3:0]));
        check("stall4",   256'(stl4), 256'(m_cnt[1][3:0]));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_run(input int k);
        if_id_d  = mk_a(32'h100 + 32'(k) * 4, ADD_A + (32'(k) << 7));
        id_ex_d  = mk_b(ADD_A, 5'd2, 1'b0, 32'h2000 + 32'(k));
        ex_mem_d = mk_c(32'h3000 + 32'(k));
        mem_wb_d = mk_d(32'h4000 + 32'(k));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin : stim
        if_id_reg  sav_a;
        ex_mem_reg sav_c;
        reset = 1'b0; ex_redirect = 1'b0; dmem_busy = 1'b0;
        set_run(9);
        tick(); tick();
        check("rst_A_nop",   256'(a_q.Curr_Instr), 256'(NOP));
        check("rst_B_nop",   256'(b_q.Curr_Instr), 256'(NOP));
        check("rst_cyc",     256'(cyc), 256'(0));
        check("rst_pcw",     256'(pcw), 256'(0));
        reset = 1'b1; #1;
        check("first_pcw",   256'(pcw), 256'(1));

        for (int k = 0; k < 4; k++) begin
            set_run(k);
            tick();
        end

        // Load x5 in B, consumer in A: one stall cycle.
        id_ex_d = mk_b(LW_X5, 5'd5, 1'b1, 32'h55);
        if_id_d = mk_a(32'h200, ADD_657);
        tick();
        if_id_d = mk_a(32'h204, ADD_A);
        id_ex_d = mk_b(ADD_657, 5'd6, 1'b0, 32'h66);
        #1 check("ls_pcw", 256'(pcw), 256'(0));
        tick();
        check("ls_A_hold",  256'(a_q.Curr_Instr), 256'(ADD_657));
        check("ls_B_bub",   256'(b_q.Curr_Instr), 256'(NOP));
        check("ls_B_mr",    256'(b_q.MemRead),    256'(0));
        check("ls_cnt",     256'(stl), 256'(1));
        check("ls_state",   256'(st),  256'(1));
        #1 check("ls_next_pcw", 256'(pcw), 256'(1));
        tick();
        check("ls_next_run", 256'(st), 256'(0));

        // Load to x0 followed by an x0 consumer: no stall.
        id_ex_d = mk_b(LW_X0, 5'd0, 1'b1, 32'h77);
        if_id_d = mk_a(32'h300, ADD_600);
        tick();
        #1 check("x0_pcw", 256'(pcw), 256'(1));
        set_run(5);
        tick();
        check("x0_cnt", 256'(stl), 256'(1));

        // Redirect coinciding with a load-use hazard resolves as FLUSH.
        do_reset();
        id_ex_d = mk_b(LW_X5, 5'd5, 1'b1, 32'h88);
        if_id_d = mk_a(32'h400, ADD_657);
        tick();
        ex_redirect = 1'b1;
        sav_c = mk_c(32'hC0DE);
        ex_mem_d = sav_c;
        tick();
        ex_redirect = 1'b0;
        check("fl_A", 256'(a_q.Curr_Instr), 256'(NOP));
        check("fl_B", 256'(b_q.Curr_Instr), 256'(NOP));
        check("fl_C", 256'(c_q), 256'(sav_c));
        check("fl_state", 256'(st), 256'(2));
        check("fl_cnt", 256'(fls), 256'(1));
        check("fl_stall", 256'(stl), 256'(0));

        // Reset in the middle of a load-use stall.
        id_ex_d = mk_b(LW_X5, 5'd5, 1'b1, 32'h99);
        if_id_d = mk_a(32'h500, ADD_657);
        tick();
        do_reset();
        check("rs_stall", 256'(stl), 256'(0));
        check("rs_A",     256'(a_q.Curr_Instr), 256'(NOP));

        // Freeze for 3 cycles with redirect held, then FLUSH.
        sav_a = mk_a(32'h600, ADD_A);
        if_id_d = sav_a;
        set_run(6); if_id_d = sav_a;
        tick();
        ex_redirect = 1'b1; dmem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_run(20 + k);
            #1 check("fz_pcw", 256'(pcw), 256'(0));
            tick();
        end
        check("fz_A", 256'(a_q), 256'(sav_a));
        check("fz_cnt", 256'(frz), 256'(3));
        check("fz_state", 256'(st), 256'(3));
        dmem_busy = 1'b0;
        tick();
        ex_redirect = 1'b0;
        check("fz_then_flush", 256'(st), 256'(2));
        check("fz_flush_cnt", 256'(fls), 256'(1));

        // Reset in the middle of a freeze.
        dmem_busy = 1'b1;
        tick();
        do_reset();
        dmem_busy = 1'b0;
        check("rf_freeze", 256'(frz), 256'(0));
        check("rf_A", 256'(a_q.Curr_Instr), 256'(NOP));

        // 16 stalls: 4-bit build wraps stall_cnt to 0.
        id_ex_d = mk_b(LW_X5, 5'd5, 1'b1, 32'hAB);
        if_id_d = mk_a(32'h700, ADD_657);
        for (int k = 0; k < 16; k++) begin
            tick(); tick();
            if (k == 14) check("wrap_15", 256'(stl4), 256'(15));
        end
        check("wrap_0",  256'(stl4), 256'(0));
        check("wrap_32", 256'(stl),  256'(16));

        set_run(1);
        tick(); tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
